// File: rtl/tremolo_modulator_if.sv
// tremolo_modulator_if: control, sample-in and sample-out signals of the tremolo modulator.
interface tremolo_modulator_if;
   logic [31:0]        frequency;
   logic               disabled;
   logic signed [15:0] sample_in;
   logic               in_valid;
   logic signed [15:0] sample_out;
   logic               out_valid;
   logic [7:0]         lfo;
   modport master (output frequency, disabled, sample_in, in_valid, input sample_out, out_valid, lfo);
   modport slave (input frequency, disabled, sample_in, in_valid, output sample_out, out_valid, lfo);
endinterface

// File: rtl/tremolo_modulator.sv
// tremolo_modulator: triangle-LFO amplitude modulation of an audio stream, two-stage pipeline.
module tremolo_modulator #(
   parameter int unsigned CLK_HZ = 50_000_000,
   parameter int unsigned DEPTH  = 192
) (
   input logic                CLK,
   input logic                RST,
   tremolo_modulator_if.slave bus
);
   logic [31:0]        acc_q, acc_d;
   logic [7:0]         lfo_q, lfo_d;
   logic               dir_q, dir_d;
   logic [32:0]        sum, diff;
   logic               tick;
   logic [15:0]        dprod;
   logic [8:0]         gain;
   logic               s1_vld_q, s1_dis_q, out_valid_q;
   logic signed [15:0] s1_sample_q, sample_out_q, sample_out_d;
   logic [8:0]         s1_gain_q;
   logic signed [25:0] prod;
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, bus.frequency};
      diff  = sum - 33'(CLK_HZ);
      tick  = sum >= 33'(CLK_HZ);
      // saturate so an over-range frequency still yields exactly one tick per cycle
      acc_d = bus.disabled ? 32'd0 :
              !tick ? sum[31:0] :
              (diff >= 33'(CLK_HZ)) ? 32'(CLK_HZ - 1) : diff[31:0];
      lfo_d = bus.disabled ? 8'd0 :
              !tick ? lfo_q :
              !dir_q ? ((lfo_q == 8'd255) ? 8'd254 : lfo_q + 8'd1) :
              ((lfo_q == 8'd0) ? 8'd1 : lfo_q - 8'd1);
      dir_d = bus.disabled ? 1'b0 :
              !tick ? dir_q :
              !dir_q ? (lfo_q == 8'd255) : (lfo_q != 8'd0);
      dprod = lfo_q * 8'(DEPTH);
      gain  = 9'd256 - {1'b0, 8'(dprod >> 8)};
      prod  = 26'(s1_sample_q) * 26'($signed({1'b0, s1_gain_q}));
      sample_out_d = s1_dis_q ? s1_sample_q : 16'(prod >>> 8);
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         acc_q        <= '0;
         lfo_q        <= '0;
         dir_q        <= 1'b0;
         s1_vld_q     <= 1'b0;
         s1_dis_q     <= 1'b0;
         s1_sample_q  <= '0;
         s1_gain_q    <= '0;
         out_valid_q  <= 1'b0;
         sample_out_q <= '0;
      end else begin
         acc_q       <= acc_d;
         lfo_q       <= lfo_d;
         dir_q       <= dir_d;
         s1_vld_q    <= bus.in_valid;
         out_valid_q <= s1_vld_q;
         if (bus.in_valid) begin
            s1_sample_q <= bus.sample_in;
            s1_gain_q   <= gain;
            s1_dis_q    <= bus.disabled;
         end
         if (s1_vld_q) sample_out_q <= sample_out_d;
      end
   end
   assign bus.sample_out = sample_out_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.lfo        = lfo_q;
endmodule

// File: doc/tremolo_modulator.md
# tremolo_modulator

Audio-path stage directly downstream of the tremolo controller. Consumes the controller's `frequency` and `disabled` outputs, runs a triangle low-frequency oscillator (LFO) stepped at `frequency` ticks per second, and scales each incoming audio sample by an LFO-derived gain. Sits between the sample source (codec receive path) and the next effect or codec transmit path. When `disabled` is high, samples pass through unmodified with the same latency.

## Interface

**Parameters**
- `CLK_HZ`, default 50_000_000: CLK frequency in Hz; modulus of the tick accumulator.
- `DEPTH`, default 192: modulation depth, range 0..255; 0 means no modulation.

**Ports**
- `CLK` input 1: system clock; all logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `frequency` input 32: LFO tick rate in ticks/s, from the tremolo controller. Unsigned.
- `disabled` input 1: bypass request, from the tremolo controller.
- `sample_in` input 16: signed two's-complement audio sample.
- `in_valid` input 1: `sample_in` is valid this cycle. Single-cycle strobe; no backpressure.
- `sample_out` output 16: signed processed sample.
- `out_valid` output 1: `sample_out` is valid this cycle.
- `lfo` output 8: current LFO value, for debug and LEDs.

## Operation

- **Tick generator:** 32-bit accumulator `acc`.
  - Each cycle: if `acc + frequency >= CLK_HZ`, then `acc <= acc + frequency - CLK_HZ` and `tick = 1`; otherwise `acc <= acc + frequency`.
  - Compute the sum in 33 bits so there is no overflow.
  - If `frequency >= CLK_HZ`, clamp to exactly one tick per cycle. The accumulator saturates at `CLK_HZ-1` and never exceeds it.
  - `frequency = 0` produces no ticks; the LFO holds its value.
  - A change of `frequency` mid-run takes effect the next cycle. `acc` is not cleared.
- **LFO:** 8-bit `lfo` plus a direction bit `dir` (0 = up).
  - On each tick: if up and `lfo == 255`, then `dir <= down`, `lfo <= 254`.
  - If down and `lfo == 0`, then `dir <= up`, `lfo <= 1`.
  - Otherwise `lfo` moves ±1.
  - Full period is 510 ticks. At `frequency = 19531` this is about 26.1 ms.
- **Gain:** `depth_term = (lfo * DEPTH) >> 8`, range 0..254. `gain = 256 - depth_term`, 9-bit unsigned, range 2..256.
- **Datapath:** two register stages.
  - **Stage 1**, on `in_valid`: capture `sample_in`, `gain` and `disabled`.
  - **Stage 2:** `prod = sample * gain`, 26-bit signed. `sample_out = prod[23:8]`, an arithmetic shift right by 8 (truncation toward -inf).
    - When `gain = 256` the output equals the input exactly.
    - If the captured `disabled` is set, `sample_out = sample`.
  - `out_valid` is `in_valid` delayed by 2 cycles.
- **Disabled:** while `disabled` is 1, `acc`, `lfo` and `dir` are held at their reset values. On re-enable the LFO restarts from 0, going up, at full gain.
  - A sample captured in Stage 1 uses the `disabled` value of its capture cycle, even if `disabled` changes before Stage 2.

## Timing

- **Reset:** while `RST` is sampled high:
  - `acc = 0`, `lfo = 0`, `dir = up`.
  - Pipeline valids cleared, `out_valid = 0`, `sample_out = 0`.
  - Reset takes priority over every other event. An in-flight sample at reset is dropped and never appears on the output.
- **Latency:** `in_valid` at cycle N gives `out_valid` at cycle N+2 with the corresponding `sample_out`. Back-to-back `in_valid` every cycle is supported at full throughput.
- **`sample_out` hold:** `sample_out` holds its last value when `out_valid = 0`.
- **Gain sampling:** the gain is taken from `lfo` as registered in the capture cycle, before that cycle's tick update. A tick and `in_valid` in the same cycle therefore use the pre-tick `lfo`.
- **`lfo` output:** `lfo` changes on the cycle after the tick condition is met.

## Test plan

- **Reset values:** assert `RST` for 2 cycles with random inputs -> `sample_out = 0`, `out_valid = 0`, `lfo = 0` on every cycle during reset and on the first cycle after it.
- **Bypass:** `disabled = 1`, `frequency = 25_000_000`, `sample_in` = 1000 then -32768 on consecutive cycles -> outputs 1000 then -32768 at N+2 and N+3. `lfo` stays 0.
- **Full-gain path:** `disabled = 0`, `frequency = 0`, `sample_in = 1000` -> `sample_out = 1000` after 2 cycles; `lfo` stays 0.
- **Tick rate and triangle:**
  - `frequency = 25_000_000` (`CLK_HZ` = 50 M) -> a tick every 2 cycles.
  - `lfo` reaches 255 after 510 cycles, then 254; it returns to 0 after 1020 cycles, then goes to 1.
  - With `frequency = 60_000_000` -> one tick per cycle, no overflow.
- **Max attenuation:** `DEPTH = 255`, hold at `lfo = 255`, `sample_in = -32768` -> `gain = 2`, `sample_out = -256`. With `sample_in = 32767` -> `sample_out = 255`.
- **Mid-operation events:**
  - Toggle `disabled` 1 -> 0 mid-stream -> each sample follows the `disabled` value at its own capture, and `lfo` restarts at 0.
  - Assert `RST` one cycle after `in_valid` -> no `out_valid` is produced.
